instruction_fetch_arbiter: RTL and testbench

INSTRUCTION_FETCH_ARBITER -- requirements
Module: instruction_fetch_arbiter

---
 rtl/instruction_fetch_arbiter_pkg.sv | 13 +
 rtl/instruction_fetch_arbiter_next_pc.sv | 57 +++++
 rtl/instruction_fetch_arbiter.sv | 84 ++++++++
 tb/tb_instruction_fetch_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_arbiter_pkg.sv
// Shared sizing and FSM encoding for the instruction fetch arbiter and its next-PC logic.
package instruction_fetch_arbiter_pkg;

   localparam int DefaultMemDepth = 256;
   localparam int AddrWidth       = $clog2(DefaultMemDepth);
   localparam int InstrWidth      = 32;

   typedef logic [0:0] fetchState_t;

   localparam fetchState_t IDLE  = 1'b0;
   localparam fetchState_t FETCH = 1'b1;

endpackage

// File: rtl/instruction_fetch_arbiter_next_pc.sv
// Chooses the address issued to memory this cycle and the fetch PC for the next cycle.
module next_pc_select
   import instruction_fetch_arbiter_pkg::*;
#(
   parameter  int MEM_DEPTH = DefaultMemDepth,
   localparam int Aw        = $clog2(MEM_DEPTH)
) (
   input  fetchState_t   state,
   input  logic          instrValid,
   input  logic          halt,
   input  logic          stall,
   input  logic          jump,
   input  logic [Aw-1:0] jumpTarget,
   input  logic          branchTaken,
   input  logic [Aw-1:0] branchTarget,
   input  logic [Aw-1:0] fetchPc,
   input  logic [Aw-1:0] pc,
   output logic [Aw-1:0] issueAddress,
   output logic [Aw-1:0] fetchPcNext,
   output logic          issueValid
);

   logic          redirect;
   logic          hold;
   logic [Aw-1:0] target;

   function automatic logic [Aw-1:0] wrapInc(input logic [Aw-1:0] a);
      return (a == Aw'(MEM_DEPTH - 1)) ? '0 : a + Aw'(1);
   endfunction

   // Redirect and stall only mean something while decode is looking at a valid word.
   assign redirect   = (state == FETCH) && instrValid && (jump || branchTaken);
   assign hold       = (state == FETCH) && instrValid && stall;
   assign target     = jump ? jumpTarget : branchTarget;
   assign issueValid = (state == FETCH) && !halt;

   always_comb begin
      issueAddress = fetchPc;
      if (redirect) begin
         issueAddress = target;
      end else if (hold) begin
         issueAddress = pc;
      end
   end

   always_comb begin
      fetchPcNext = fetchPc;
      if (halt || (state == IDLE)) begin
         fetchPcNext = '0;
      end else if (redirect) begin
         fetchPcNext = wrapInc(target);
      end else if (!hold) begin
         fetchPcNext = wrapInc(fetchPc);
      end
   end

endmodule

// File: rtl/instruction_fetch_arbiter.sv
// Shares one instruction memory port between the program loader (IDLE) and the fetch path (FETCH).
//   state | meaning
//   IDLE  | loader owns the memory port, no fetch in flight
//   FETCH | fetch path owns the memory port, loader held off
module instruction_fetch_arbiter
   import instruction_fetch_arbiter_pkg::*;
#(
   parameter  int MEM_DEPTH = DefaultMemDepth,
   localparam int AW        = $clog2(MEM_DEPTH)
) (
   input  logic                  Clock,
   input  logic                  ResetN,
   input  logic                  Run,
   input  logic                  Halt,
   input  logic                  LoadValid,
   input  logic [AW-1:0]         LoadAddress,
   input  logic [InstrWidth-1:0] LoadData,
   output logic                  LoadReady,
   input  logic                  Stall,
   input  logic                  BranchTaken,
   input  logic [AW-1:0]         BranchTarget,
   input  logic                  Jump,
   input  logic [AW-1:0]         JumpTarget,
   output logic [InstrWidth-1:0] Instruction,
   output logic                  InstrValid,
   output logic [AW-1:0]         Pc,
   output logic [AW-1:0]         MemAddress,
   output logic                  MemWriteEnable,
   output logic [InstrWidth-1:0] MemWriteData,
   input  logic [InstrWidth-1:0] MemReadData
);

   fetchState_t   state;
   logic [AW-1:0] fetchPc;
   logic [AW-1:0] fetchPcNext;
   logic [AW-1:0] issueAddress;
   logic          issueValid;

   next_pc_select #(
      .MEM_DEPTH (MEM_DEPTH)
   ) uNextPc (
      .state        (state),
      .instrValid   (InstrValid),
      .halt         (Halt),
      .stall        (Stall),
      .jump         (Jump),
      .jumpTarget   (JumpTarget),
      .branchTaken  (BranchTaken),
      .branchTarget (BranchTarget),
      .fetchPc      (fetchPc),
      .pc           (Pc),
      .issueAddress (issueAddress),
      .fetchPcNext  (fetchPcNext),
      .issueValid   (issueValid)
   );

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state      <= IDLE;
         fetchPc    <= '0;
         Pc         <= '0;
         InstrValid <= 1'b0;
      end else begin
         fetchPc    <= fetchPcNext;
         InstrValid <= issueValid;
         if (issueValid) begin
            Pc <= issueAddress;
         end
         if (Halt) begin
            state <= IDLE;
         end else if ((state == IDLE) && Run) begin
            state <= FETCH;
         end
      end
   end

   // ResetN gates the strobe so a loader request during reset can never reach memory.
   assign LoadReady      = (state == IDLE);
   assign MemWriteEnable = LoadValid && (state == IDLE) && ResetN;
   assign MemAddress     = (state == IDLE) ? LoadAddress : issueAddress;
   assign MemWriteData   = LoadData;
   assign Instruction    = MemReadData;

endmodule

// File: tb/tb_instruction_fetch_arbiter.sv
// Directed bench: loads a short program, then exercises fetch, stall, redirect, halt, reset and wrap.
module tb_instruction_fetch_arbiter;

   logic        Clock = 1'b0;
   logic        ResetN;
   logic        Run, Halt, LoadValid, Stall, BranchTaken, Jump;
   logic [7:0]  LoadAddress, BranchTarget, JumpTarget;
   logic [31:0] LoadData;
   logic        LoadReady, InstrValid, MemWriteEnable;
   logic [31:0] Instruction, MemWriteData, MemReadData;
   logic [7:0]  Pc, MemAddress;

   int checks = 0;
   int fails  = 0;

   logic [31:0] words [5] = '{32'h20090004, 32'h200A000F, 32'hAD490000, 32'h8D2B0000, 32'h296B0019};

   // Memory model: unwritten words read as 0xC0DE0000 | address.
   bit [31:0]  mem [256];
   bit [255:0] written;

   always #5 Clock = ~Clock;

   always @(posedge Clock) begin
      if (MemWriteEnable) begin
         mem[MemAddress]     <= MemWriteData;
         written[MemAddress] <= 1'b1;
      end
      MemReadData <= written[MemAddress] ? mem[MemAddress] : (32'hC0DE0000 | 32'(MemAddress));
   end

   instruction_fetch_arbiter dut (
      .Clock          (Clock),
      .ResetN         (ResetN),
      .Run            (Run),
      .Halt           (Halt),
      .LoadValid      (LoadValid),
      .LoadAddress    (LoadAddress),
      .LoadData       (LoadData),
      .LoadReady      (LoadReady),
      .Stall          (Stall),
      .BranchTaken    (BranchTaken),
      .BranchTarget   (BranchTarget),
      .Jump           (Jump),
      .JumpTarget     (JumpTarget),
      .Instruction    (Instruction),
      .InstrValid     (InstrValid),
      .Pc             (Pc),
      .MemAddress     (MemAddress),
      .MemWriteEnable (MemWriteEnable),
      .MemWriteData   (MemWriteData),
      .MemReadData    (MemReadData)
   );

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic startRun;
      Run = 1'b1;
      tick;
      Run = 1'b0;
      tick;
   endtask

   task automatic haltNow;
      Halt = 1'b1;
      tick;
      Halt = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      checks++; if (LoadReady !== 1'b1) begin fails++; $display("FAIL reset_loadready got %b want 1", LoadReady); end
      checks++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL reset_instrvalid got %b want 0", InstrValid); end
      checks++; if (Pc !== 8'd0) begin fails++; $display("FAIL reset_pc got %0d want 0", Pc); end
      LoadValid = 1'b1; LoadAddress = 8'd33; LoadData = 32'hDEADBEEF;
      #1;
      checks++; if (MemWriteEnable !== 1'b0) begin fails++; $display("FAIL reset_no_write got %b want 0", MemWriteEnable); end
      tick;
      LoadValid = 1'b0;
      ResetN = 1'b1;
      #1;
      checks++; if (LoadReady !== 1'b1) begin fails++; $display("FAIL post_reset_loadready got %b want 1", LoadReady); end
   endtask

   task automatic test_load;
      for (int i = 0; i < 5; i++) begin
         LoadValid = 1'b1; LoadAddress = 8'(i); LoadData = words[i];
         #1;
         checks++; if (LoadReady !== 1'b1) begin fails++; $display("FAIL load_ready[%0d] got %b want 1", i, LoadReady); end
         checks++; if (MemWriteEnable !== 1'b1) begin fails++; $display("FAIL load_we[%0d] got %b want 1", i, MemWriteEnable); end
         checks++; if (MemAddress !== 8'(i)) begin fails++; $display("FAIL load_addr[%0d] got %0d want %0d", i, MemAddress, i); end
         checks++; if (MemWriteData !== words[i]) begin fails++; $display("FAIL load_data[%0d] got %h want %h", i, MemWriteData, words[i]); end
         tick;
      end
      LoadValid = 1'b0;
   endtask

   task automatic test_run;
      Run = 1'b1;
      tick;
      Run = 1'b0;
      #1;
      checks++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL run_first_cycle_valid got %b want 0", InstrValid); end
      checks++; if (MemAddress !== 8'd0) begin fails++; $display("FAIL run_first_issue got %0d want 0", MemAddress); end
      checks++; if (LoadReady !== 1'b0) begin fails++; $display("FAIL run_loadready got %b want 0", LoadReady); end
      for (int k = 0; k < 5; k++) begin
         tick;
         checks++; if (InstrValid !== 1'b1) begin fails++; $display("FAIL run_valid[%0d] got %b want 1", k, InstrValid); end
         checks++; if (Pc !== 8'(k)) begin fails++; $display("FAIL run_pc[%0d] got %0d want %0d", k, Pc, k); end
         checks++; if (Instruction !== words[k]) begin fails++; $display("FAIL run_instr[%0d] got %h want %h", k, Instruction, words[k]); end
      end
      haltNow;
      checks++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL halt_valid got %b want 0", InstrValid); end
      checks++; if (LoadReady !== 1'b1) begin fails++; $display("FAIL halt_loadready got %b want 1", LoadReady); end
   endtask

   task automatic test_stall;
      startRun;
      tick;
      tick;
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (MemAddress !== 8'd2) begin fails++; $display("FAIL stall_reissue[%0d] got %0d want 2", i, MemAddress); end
         checks++; if (Pc !== 8'd2) begin fails++; $display("FAIL stall_pc[%0d] got %0d want 2", i, Pc); end
         checks++; if (Instruction !== 32'hAD490000) begin fails++; $display("FAIL stall_instr[%0d] got %h want ad490000", i, Instruction); end
         checks++; if (InstrValid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d] got %b want 1", i, InstrValid); end
         tick;
      end
      Stall = 1'b0;
      #1;
      checks++; if (Pc !== 8'd2) begin fails++; $display("FAIL stall_release_pc got %0d want 2", Pc); end
      checks++; if (MemAddress !== 8'd3) begin fails++; $display("FAIL stall_release_issue got %0d want 3", MemAddress); end
      tick;
      checks++; if (Pc !== 8'd3) begin fails++; $display("FAIL stall_after_pc got %0d want 3", Pc); end
      checks++; if (Instruction !== 32'h8D2B0000) begin fails++; $display("FAIL stall_after_instr got %h want 8d2b0000", Instruction); end
      haltNow;
   endtask

   task automatic test_redirect;
      startRun;
      tick;
      BranchTaken = 1'b1; BranchTarget = 8'd4; Jump = 1'b1; JumpTarget = 8'd0; Stall = 1'b1;
      #1;
      checks++; if (MemAddress !== 8'd0) begin fails++; $display("FAIL jump_issue got %0d want 0", MemAddress); end
      tick;
      BranchTaken = 1'b0; Jump = 1'b0; Stall = 1'b0;
      checks++; if (Pc !== 8'd0) begin fails++; $display("FAIL jump_pc got %0d want 0", Pc); end
      checks++; if (InstrValid !== 1'b1) begin fails++; $display("FAIL jump_valid got %b want 1", InstrValid); end
      checks++; if (Instruction !== words[0]) begin fails++; $display("FAIL jump_instr got %h want %h", Instruction, words[0]); end
      tick;
      checks++; if (Pc !== 8'd1) begin fails++; $display("FAIL jump_next_pc got %0d want 1", Pc); end
      BranchTaken = 1'b1; BranchTarget = 8'd4;
      tick;
      BranchTaken = 1'b0;
      checks++; if (Pc !== 8'd4) begin fails++; $display("FAIL branch_pc got %0d want 4", Pc); end
      checks++; if (Instruction !== words[4]) begin fails++; $display("FAIL branch_instr got %h want %h", Instruction, words[4]); end
      tick;
      checks++; if (Pc !== 8'd5) begin fails++; $display("FAIL branch_next_pc got %0d want 5", Pc); end
      checks++; if (Instruction !== 32'hC0DE0005) begin fails++; $display("FAIL branch_next_instr got %h want c0de0005", Instruction); end
      haltNow;
   endtask

   task automatic test_idle_ignore;
      Jump = 1'b1; JumpTarget = 8'd7; BranchTaken = 1'b1; BranchTarget = 8'd9; Stall = 1'b1; Run = 1'b1;
      tick;
      Jump = 1'b0; BranchTaken = 1'b0; Stall = 1'b0; Run = 1'b0;
      #1;
      checks++; if (MemAddress !== 8'd0) begin fails++; $display("FAIL idle_ignore_issue got %0d want 0", MemAddress); end
      tick;
      checks++; if (Pc !== 8'd0) begin fails++; $display("FAIL idle_ignore_pc got %0d want 0", Pc); end
      checks++; if (InstrValid !== 1'b1) begin fails++; $display("FAIL idle_ignore_valid got %b want 1", InstrValid); end
      haltNow;
   endtask

   task automatic test_load_during_fetch;
      startRun;
      LoadValid = 1'b1; LoadAddress = 8'd10; LoadData = 32'h12345678;
      #1;
      checks++; if (LoadReady !== 1'b0) begin fails++; $display("FAIL fetch_load_ready got %b want 0", LoadReady); end
      checks++; if (MemWriteEnable !== 1'b0) begin fails++; $display("FAIL fetch_load_we got %b want 0", MemWriteEnable); end
      tick;
      checks++; if (Pc !== 8'd1) begin fails++; $display("FAIL fetch_load_pc got %0d want 1", Pc); end
      checks++; if (MemWriteEnable !== 1'b0) begin fails++; $display("FAIL fetch_load_we2 got %b want 0", MemWriteEnable); end
      haltNow;
      checks++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL pending_halt_valid got %b want 0", InstrValid); end
      checks++; if (LoadReady !== 1'b1) begin fails++; $display("FAIL pending_ready got %b want 1", LoadReady); end
      checks++; if (MemWriteEnable !== 1'b1) begin fails++; $display("FAIL pending_we got %b want 1", MemWriteEnable); end
      checks++; if (MemAddress !== 8'd10) begin fails++; $display("FAIL pending_addr got %0d want 10", MemAddress); end
      tick;
      LoadValid = 1'b0;
      startRun;
      Jump = 1'b1; JumpTarget = 8'd10;
      tick;
      Jump = 1'b0;
      checks++; if (Pc !== 8'd10) begin fails++; $display("FAIL pending_fetch_pc got %0d want 10", Pc); end
      checks++; if (Instruction !== 32'h12345678) begin fails++; $display("FAIL pending_fetch_instr got %h want 12345678", Instruction); end
      haltNow;
   endtask

   task automatic test_reset_mid_fetch;
      startRun;
      tick;
      tick;
      tick;
      checks++; if (Pc !== 8'd3) begin fails++; $display("FAIL midreset_pre_pc got %0d want 3", Pc); end
      ResetN = 1'b0;
      #1;
      checks++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL midreset_valid got %b want 0", InstrValid); end
      checks++; if (Pc !== 8'd0) begin fails++; $display("FAIL midreset_pc got %0d want 0", Pc); end
      checks++; if (LoadReady !== 1'b1) begin fails++; $display("FAIL midreset_ready got %b want 1", LoadReady); end
      tick;
      ResetN = 1'b1;
      tick;
      checks++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL midreset_after_valid got %b want 0", InstrValid); end
      checks++; if (LoadReady !== 1'b1) begin fails++; $display("FAIL midreset_after_ready got %b want 1", LoadReady); end
   endtask

   task automatic test_wrap;
      startRun;
      Jump = 1'b1; JumpTarget = 8'd254;
      tick;
      Jump = 1'b0;
      checks++; if (Pc !== 8'd254) begin fails++; $display("FAIL wrap_pc254 got %0d want 254", Pc); end
      tick;
      checks++; if (Pc !== 8'd255) begin fails++; $display("FAIL wrap_pc255 got %0d want 255", Pc); end
      checks++; if (Instruction !== 32'hC0DE00FF) begin fails++; $display("FAIL wrap_instr255 got %h want c0de00ff", Instruction); end
      tick;
      checks++; if (Pc !== 8'd0) begin fails++; $display("FAIL wrap_pc0 got %0d want 0", Pc); end
      checks++; if (Instruction !== words[0]) begin fails++; $display("FAIL wrap_instr0 got %h want %h", Instruction, words[0]); end
      tick;
      checks++; if (Pc !== 8'd1) begin fails++; $display("FAIL wrap_pc1 got %0d want 1", Pc); end
      Halt = 1'b1; Run = 1'b1; Jump = 1'b1; JumpTarget = 8'd20; Stall = 1'b1;
      tick;
      Halt = 1'b0; Run = 1'b0; Jump = 1'b0; Stall = 1'b0;
      checks++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL halt_prio_valid got %b want 0", InstrValid); end
      checks++; if (LoadReady !== 1'b1) begin fails++; $display("FAIL halt_prio_ready got %b want 1", LoadReady); end
      tick;
      checks++; if (LoadReady !== 1'b1) begin fails++; $display("FAIL halt_prio_stay_idle got %b want 1", LoadReady); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      ResetN = 1'b0; Run = 1'b0; Halt = 1'b0; LoadValid = 1'b0; Stall = 1'b0;
      BranchTaken = 1'b0; Jump = 1'b0; LoadAddress = '0; BranchTarget = '0; JumpTarget = '0; LoadData = '0;
      test_reset;
      test_load;
      test_run;
      test_stall;
      test_redirect;
      test_idle_ignore;
      test_load_during_fetch;
      test_reset_mid_fetch;
      test_wrap;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
